// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: decodes size/sign, checks alignment, runs a
// req/ack data-memory access and returns extended load data to MEM/WB.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   pipeline side : i_flush, i_insn_vld, i_mem_ren, i_mem_wren, i_instr,
//                   i_alu_data (byte address), i_rs2_data (store data)
//   memory side   : o_dmem_req/we/addr/be/wdata, i_dmem_ack, i_dmem_rdata
//   results       : o_ld_data, o_stall, o_done, o_misaligned, o_bus_err
module mem_lsu #(
    parameter int P_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_insn_vld,
    input  logic        i_mem_ren,
    input  logic        i_mem_wren,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    output logic [31:0] o_ld_data,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(P_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  sz_q;
    logic [1:0]  off_q;
    logic        sgn_q;

    logic [2:0]  f3;
    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        memop;
    logic        mis;
    logic        acc;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    logic unused_bits;
    assign unused_bits = ^{i_instr[31:15], i_instr[11:0]};

    assign f3    = i_instr[14:12];
    assign is_b  = (f3[1:0] == 2'b00);
    assign is_h  = (f3[1:0] == 2'b01);
    assign is_w  = f3[1];
    assign memop = i_insn_vld & (i_mem_ren | i_mem_wren) & ~i_flush;
    assign mis   = (is_h & i_alu_data[0]) |
                   (is_w & (|i_alu_data[1:0]));
    assign acc   = memop & ~mis;

    assign o_misaligned = memop & mis;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = i_rs2_data;
        unique case (1'b1)
            is_b: begin
                be_c    = 4'b0001 << i_alu_data[1:0];
                wdata_c = {4{i_rs2_data[7:0]}};
            end
            is_h: begin
                be_c    = 4'b0011 << i_alu_data[1:0];
                wdata_c = {2{i_rs2_data[15:0]}};
            end
            is_w: begin
                be_c    = 4'b1111;
                wdata_c = i_rs2_data;
            end
            default: ;
        endcase
    end

    // Reset gates stall so an abandoned access releases the pipe at once.
    always_comb begin
        o_stall = 1'b0;
        unique case (state)
            S_IDLE:  o_stall = acc;
            S_WAIT:  o_stall = 1'b1;
            default: o_stall = 1'b0;
        endcase
        o_stall = o_stall & i_reset;
    end

    function automatic logic [31:0] extract(
        input logic [31:0] rd,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic        sgn
    );
        logic [31:0] w;
        w = rd >> {off, 3'b000};
        if (sz == 2'b00)
            extract = {{24{sgn & w[7]}}, w[7:0]};
        else if (sz == 2'b01)
            extract = {{16{sgn & w[15]}}, w[15:0]};
        else
            extract = w;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            sz_q         <= '0;
            off_q        <= '0;
            sgn_q        <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= '0;
            o_dmem_wdata <= '0;
            o_ld_data    <= '0;
            o_done       <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_bus_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (acc) begin
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= i_mem_wren;
                        o_dmem_addr  <= {i_alu_data[31:2], 2'b00};
                        o_dmem_be    <= be_c;
                        o_dmem_wdata <= wdata_c;
                        sz_q         <= f3[1:0];
                        sgn_q        <= ~f3[2];
                        off_q        <= i_alu_data[1:0];
                        cnt          <= '0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_dmem_ack) begin
                        if (!o_dmem_we)
                            o_ld_data <= extract(i_dmem_rdata, off_q,
                                                 sz_q, sgn_q);
                        o_dmem_req <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= S_DONE;
                    end else if (cnt == TMO_LAST) begin
                        o_ld_data  <= '0;
                        o_dmem_req <= 1'b0;
                        o_done     <= 1'b1;
                        o_bus_err  <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
